// File: rtl/rx_frame_decoder_if.sv
// Byte-stream bus of the receive frame decoder: joined input bytes in,
// decoded packet bytes and control-symbol reports out.
interface rx_frame_decoder_if;
  logic       ENB;
  logic [7:0] IN_DATA;
  logic       IN_VALID;
  logic [7:0] OUT_DATA;
  logic       OUT_DVALID;
  logic       OUT_SOP;
  logic       OUT_EOP;
  logic       OUT_ABORT;
  logic [3:0] OUT_CTRL;
  logic       OUT_CVALID;
  logic       OUT_ALIGNED;
  logic       OUT_ERR;

  // Upstream side: supplies bytes, observes the decoded stream.
  modport master (
    output ENB, IN_DATA, IN_VALID,
    input  OUT_DATA, OUT_DVALID, OUT_SOP, OUT_EOP, OUT_ABORT,
    input  OUT_CTRL, OUT_CVALID, OUT_ALIGNED, OUT_ERR
  );

  // Decoder side.
  modport slave (
    input  ENB, IN_DATA, IN_VALID,
    output OUT_DATA, OUT_DVALID, OUT_SOP, OUT_EOP, OUT_ABORT,
    output OUT_CTRL, OUT_CVALID, OUT_ALIGNED, OUT_ERR
  );
endinterface

// File: rtl/rx_frame_decoder.sv
// Receive frame decoder: aligns on COM pairs, reports control symbols and
// delimits STP/SDP..END/EDB packets through a one-byte hold register.
module rx_frame_decoder #(
  parameter logic [7:0] COM     = 8'hBC,
  parameter logic [7:0] PAD     = 8'hF7,
  parameter logic [7:0] SKP     = 8'h1C,
  parameter logic [7:0] STP     = 8'hFB,
  parameter logic [7:0] SDP     = 8'h5C,
  parameter logic [7:0] END     = 8'hFD,
  parameter logic [7:0] EDB     = 8'hFE,
  parameter logic [7:0] FTS     = 8'h3C,
  parameter logic [7:0] IDL     = 8'h7C,
  parameter int         MAX_LEN = 64
) (
  input  logic               CLK,
  input  logic               reset,
  rx_frame_decoder_if.slave  bus
);

  localparam logic [1:0] S_UNALIGNED = 2'd0;
  localparam logic [1:0] S_IDLE      = 2'd1;
  localparam logic [1:0] S_PKT       = 2'd2;

  localparam logic [3:0] C_DATA = 4'd0;
  localparam logic [3:0] C_COM  = 4'd1;
  localparam logic [3:0] C_PAD  = 4'd2;
  localparam logic [3:0] C_SKP  = 4'd3;
  localparam logic [3:0] C_STP  = 4'd4;
  localparam logic [3:0] C_SDP  = 4'd5;
  localparam logic [3:0] C_END  = 4'd6;
  localparam logic [3:0] C_EDB  = 4'd7;
  localparam logic [3:0] C_FTS  = 4'd8;
  localparam logic [3:0] C_IDL  = 4'd9;
  localparam logic [3:0] C_UNK  = 4'd15;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  function automatic logic [3:0] decode(input logic [7:0] b);
    logic [3:0] c;
    case (b)
      COM:     c = C_COM;
      PAD:     c = C_PAD;
      SKP:     c = C_SKP;
      STP:     c = C_STP;
      SDP:     c = C_SDP;
      END:     c = C_END;
      EDB:     c = C_EDB;
      FTS:     c = C_FTS;
      IDL:     c = C_IDL;
      default: c = C_UNK;
    endcase
    return c;
  endfunction

  logic [1:0] state_q,      state_d;
  logic       com_seen_q,   com_seen_d;
  logic [7:0] len_q,        len_d;
  logic       sop_flag_q,   sop_flag_d;
  logic       hold_valid_q, hold_valid_d;
  logic [7:0] hold_data_q,  hold_data_d;
  logic       aligned_q,    aligned_d;
  logic [7:0] data_q,       data_d;
  logic       dvalid_q,     dvalid_d;
  logic       sop_q,        sop_d;
  logic       eop_q,        eop_d;
  logic       abort_q,      abort_d;
  logic [3:0] ctrl_q,       ctrl_d;
  logic       cvalid_q,     cvalid_d;
  logic       err_q,        err_d;

  logic       accept;
  logic [3:0] sym;
  logic       is_com;

  assign accept = bus.ENB & bus.IN_VALID;
  assign sym    = decode(bus.IN_DATA);
  assign is_com = (bus.IN_DATA == COM);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; a missing default here would infer a latch.
    state_d      = state_q;
    com_seen_d   = com_seen_q;
    len_d        = len_q;
    sop_flag_d   = sop_flag_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    aligned_d    = aligned_q;
    data_d       = data_q;
    ctrl_d       = ctrl_q;
    dvalid_d     = 1'b0;
    sop_d        = 1'b0;
    eop_d        = 1'b0;
    abort_d      = 1'b0;
    cvalid_d     = 1'b0;
    err_d        = 1'b0;

    if (accept) begin
      case (state_q)
        S_UNALIGNED: begin
          if (is_com && com_seen_q) begin
            state_d    = S_IDLE;
            com_seen_d = 1'b0;
            aligned_d  = 1'b1;
          end else begin
            com_seen_d = is_com;
          end
        end

        S_IDLE: begin
          ctrl_d   = sym;
          cvalid_d = 1'b1;
          case (sym)
            C_COM, C_PAD, C_SKP, C_FTS, C_IDL: ;
            C_STP, C_SDP: begin
              state_d      = S_PKT;
              len_d        = 8'd0;
              sop_flag_d   = 1'b1;
              hold_valid_d = 1'b0;
            end
            default: begin
              // END/EDB outside a packet or a non-code byte: alignment is suspect.
              err_d      = 1'b1;
              state_d    = S_UNALIGNED;
              aligned_d  = 1'b0;
              com_seen_d = 1'b0;
            end
          endcase
        end

        S_PKT: begin
          if (sym == C_END || sym == C_EDB) begin
            ctrl_d       = sym;
            cvalid_d     = 1'b1;
            state_d      = S_IDLE;
            hold_valid_d = 1'b0;
            sop_flag_d   = 1'b0;
            if (hold_valid_q) begin
              data_d   = hold_data_q;
              dvalid_d = 1'b1;
              sop_d    = sop_flag_q;
              eop_d    = 1'b1;
              abort_d  = (sym == C_EDB);
            end else begin
              err_d = 1'b1;
            end
          end else if (len_q == MAX_LEN_B) begin
            // One byte past the limit: close the packet as aborted, drop the new byte.
            err_d        = 1'b1;
            state_d      = S_UNALIGNED;
            aligned_d    = 1'b0;
            com_seen_d   = 1'b0;
            hold_valid_d = 1'b0;
            sop_flag_d   = 1'b0;
            if (hold_valid_q) begin
              data_d   = hold_data_q;
              dvalid_d = 1'b1;
              sop_d    = sop_flag_q;
              eop_d    = 1'b1;
              abort_d  = 1'b1;
            end
          end else begin
            len_d        = len_q + 8'd1;
            hold_data_d  = bus.IN_DATA;
            hold_valid_d = 1'b1;
            if (hold_valid_q) begin
              data_d     = hold_data_q;
              dvalid_d   = 1'b1;
              sop_d      = sop_flag_q;
              sop_flag_d = 1'b0;
            end
          end
        end

        default: begin
          state_d      = S_UNALIGNED;
          aligned_d    = 1'b0;
          com_seen_d   = 1'b0;
          hold_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples the values
    // present before the edge, independent of statement order.
    if (reset) begin
      state_q      <= S_UNALIGNED;
      com_seen_q   <= 1'b0;
      len_q        <= 8'd0;
      sop_flag_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      aligned_q    <= 1'b0;
      data_q       <= 8'h00;
      dvalid_q     <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      abort_q      <= 1'b0;
      ctrl_q       <= C_DATA;
      cvalid_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      com_seen_q   <= com_seen_d;
      len_q        <= len_d;
      sop_flag_q   <= sop_flag_d;
      hold_valid_q <= hold_valid_d;
      aligned_q    <= aligned_d;
      data_q       <= data_d;
      dvalid_q     <= dvalid_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      abort_q      <= abort_d;
      ctrl_q       <= ctrl_d;
      cvalid_q     <= cvalid_d;
      err_q        <= err_d;
    end
  end

  // NOTE: the held byte is pure datapath guarded by hold_valid_q, so it is
  // left out of reset; clearing the valid bit is enough to discard it.
  always_ff @(posedge CLK) begin
    hold_data_q <= hold_data_d;
  end

  assign bus.OUT_DATA    = data_q;
  assign bus.OUT_DVALID  = dvalid_q;
  assign bus.OUT_SOP     = sop_q;
  assign bus.OUT_EOP     = eop_q;
  assign bus.OUT_ABORT   = abort_q;
  assign bus.OUT_CTRL    = ctrl_q;
  assign bus.OUT_CVALID  = cvalid_q;
  assign bus.OUT_ALIGNED = aligned_q;
  assign bus.OUT_ERR     = err_q;

endmodule

// File: tb/tb_rx_frame_decoder.sv
// Directed bench for rx_frame_decoder (MAX_LEN=4): alignment, packets,
// boundary packets, stalls, overrun, idle errors and mid-packet reset.
module tb_rx_frame_decoder;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  rx_frame_decoder_if bus ();

  rx_frame_decoder #(.MAX_LEN(4)) dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Present one byte, let one rising edge take it, then sample 1 ns later.
  task automatic drive(input logic [7:0] d, input logic v, input logic e);
    bus.IN_DATA  = d;
    bus.IN_VALID = v;
    bus.ENB      = e;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    drive(d, 1'b1, 1'b1);
  endtask

  task automatic expect_data(input string tag, input logic [7:0] d,
                             input logic sop, input logic eop, input logic abort);
    check({tag, ".dvalid"}, bus.OUT_DVALID, 1'b1);
    check({tag, ".data"},   bus.OUT_DATA,   d);
    check({tag, ".sop"},    bus.OUT_SOP,    sop);
    check({tag, ".eop"},    bus.OUT_EOP,    eop);
    check({tag, ".abort"},  bus.OUT_ABORT,  abort);
  endtask

  task automatic expect_ctrl(input string tag, input logic [3:0] c, input logic err);
    check({tag, ".cvalid"}, bus.OUT_CVALID, 1'b1);
    check({tag, ".ctrl"},   bus.OUT_CTRL,   c);
    check({tag, ".err"},    bus.OUT_ERR,    err);
  endtask

  initial begin
    bus.ENB = 1'b0; bus.IN_DATA = 8'h00; bus.IN_VALID = 1'b0;

    // Reset with a COM on the bus: reset has priority.
    reset = 1'b1;
    drive(8'hBC, 1'b1, 1'b1);
    drive(8'hBC, 1'b1, 1'b1);
    check("rst.data",    bus.OUT_DATA,    8'h00);
    check("rst.ctrl",    bus.OUT_CTRL,    4'h0);
    check("rst.dvalid",  bus.OUT_DVALID,  1'b0);
    check("rst.cvalid",  bus.OUT_CVALID,  1'b0);
    check("rst.aligned", bus.OUT_ALIGNED, 1'b0);
    check("rst.err",     bus.OUT_ERR,     1'b0);
    check("rst.flags",   {bus.OUT_SOP, bus.OUT_EOP, bus.OUT_ABORT}, 3'b000);
    reset = 1'b0;

    // Alignment: BC,00,BC,BC; the 00 breaks the first pair.
    send(8'hBC); check("aln.bc1", bus.OUT_ALIGNED, 1'b0);
    send(8'h00); check("aln.00",  bus.OUT_ALIGNED, 1'b0);
    send(8'hBC); check("aln.bc2", bus.OUT_ALIGNED, 1'b0);
    send(8'hBC); check("aln.bc3", bus.OUT_ALIGNED, 1'b1);

    // Idle symbols are reported, state stays put.
    send(8'h7C); expect_ctrl("idl", 4'd9, 1'b0);
    send(8'h1C); expect_ctrl("skp", 4'd3, 1'b0);
    send(8'hF7); expect_ctrl("pad", 4'd2, 1'b0);
    check("idle.aligned", bus.OUT_ALIGNED, 1'b1);

    // Disabled cycle: byte 55 would be an error but is not accepted.
    drive(8'h55, 1'b1, 1'b0);
    check("enb0.err",    bus.OUT_ERR,     1'b0);
    check("enb0.cvalid", bus.OUT_CVALID,  1'b0);
    check("enb0.ctrl",   bus.OUT_CTRL,    4'd2);

    // Packet FB,11,22,33,FD.
    send(8'hFB); expect_ctrl("p1.stp", 4'd4, 1'b0);
                 check("p1.stp.dvalid", bus.OUT_DVALID, 1'b0);
    send(8'h11); check("p1.11.dvalid",  bus.OUT_DVALID, 1'b0);
                 check("p1.11.cvalid",  bus.OUT_CVALID, 1'b0);
    send(8'h22); expect_data("p1.b0", 8'h11, 1'b1, 1'b0, 1'b0);
    send(8'h33); expect_data("p1.b1", 8'h22, 1'b0, 1'b0, 1'b0);
    send(8'hFD); expect_data("p1.b2", 8'h33, 1'b0, 1'b1, 1'b0);
                 expect_ctrl("p1.end", 4'd6, 1'b0);
    drive(8'h00, 1'b0, 1'b1);
    check("p1.idle.dvalid", bus.OUT_DVALID, 1'b0);
    check("p1.idle.hold",   bus.OUT_DATA,   8'h33);
    check("p1.idle.eop",    bus.OUT_EOP,    1'b0);

    // Single-byte nullified packet FB,AA,FE.
    send(8'hFB); send(8'hAA);
    send(8'hFE); expect_data("p2", 8'hAA, 1'b1, 1'b1, 1'b1);
                 expect_ctrl("p2.edb", 4'd7, 1'b0);

    // Empty packet FB,FD: error, no data, back to IDLE.
    send(8'hFB);
    send(8'hFD); check("p3.err",    bus.OUT_ERR,    1'b1);
                 check("p3.dvalid", bus.OUT_DVALID, 1'b0);
    send(8'h7C); expect_ctrl("p3.idle", 4'd9, 1'b0);
                 check("p3.aligned", bus.OUT_ALIGNED, 1'b1);

    // Stall with in-packet code bytes: FB,BC,[gap x3],1C,FD.
    send(8'hFB); send(8'hBC);
    check("p4.bc.cvalid", bus.OUT_CVALID, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(8'hFD, 1'b0, 1'b1);
      check("p4.stall.dvalid", bus.OUT_DVALID, 1'b0);
      check("p4.stall.cvalid", bus.OUT_CVALID, 1'b0);
    end
    send(8'h1C); expect_data("p4.b0", 8'hBC, 1'b1, 1'b0, 1'b0);
    send(8'hFD); expect_data("p4.b1", 8'h1C, 1'b0, 1'b1, 1'b0);

    // Overrun with MAX_LEN=4: FB,01..05; byte 04 closes aborted.
    send(8'hFB); send(8'h01);
    send(8'h02); expect_data("ov.b0", 8'h01, 1'b1, 1'b0, 1'b0);
    send(8'h03); expect_data("ov.b1", 8'h02, 1'b0, 1'b0, 1'b0);
    send(8'h04); expect_data("ov.b2", 8'h03, 1'b0, 1'b0, 1'b0);
                 check("ov.b2.err", bus.OUT_ERR, 1'b0);
    send(8'h05); expect_data("ov.b3", 8'h04, 1'b0, 1'b1, 1'b1);
                 check("ov.err",     bus.OUT_ERR,     1'b1);
                 check("ov.aligned", bus.OUT_ALIGNED, 1'b0);
    send(8'hFD); check("ov.unal.dvalid", bus.OUT_DVALID, 1'b0);
                 check("ov.unal.err",    bus.OUT_ERR,    1'b0);

    // Realign, then a non-code byte in IDLE.
    send(8'hBC); send(8'hBC); check("re1.aligned", bus.OUT_ALIGNED, 1'b1);
    send(8'h55); expect_ctrl("bad", 4'd15, 1'b1);
                 check("bad.aligned", bus.OUT_ALIGNED, 1'b0);

    // Reset mid-packet: FB,11,22 then reset with a byte on the bus.
    send(8'hBC); send(8'hBC); check("re2.aligned", bus.OUT_ALIGNED, 1'b1);
    send(8'hFB); send(8'h11);
    send(8'h22); expect_data("mr.b0", 8'h11, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    drive(8'hFD, 1'b1, 1'b1);
    check("mr.eop",     bus.OUT_EOP,     1'b0);
    check("mr.dvalid",  bus.OUT_DVALID,  1'b0);
    check("mr.data",    bus.OUT_DATA,    8'h00);
    check("mr.ctrl",    bus.OUT_CTRL,    4'h0);
    check("mr.aligned", bus.OUT_ALIGNED, 1'b0);
    reset = 1'b0;
    send(8'hFD);
    check("mr.post.dvalid", bus.OUT_DVALID, 1'b0);
    check("mr.post.eop",    bus.OUT_EOP,    1'b0);
    check("mr.post.cvalid", bus.OUT_CVALID, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
